// File: rtl/dsp48a1_pkg.sv
// Shared constants for the dsp48a1 arithmetic slice: operand widths and
// the recognised OPERATION strings.
package dsp48a1_pkg;

  localparam int A_W = 18;
  localparam int B_W = 18;
  localparam int C_W = 48;
  localparam int D_W = 18;
  localparam int M_W = 36;
  localparam int P_W = 48;

  localparam string OP_ADD = "ADD";
  localparam string OP_SUB = "SUBTRACT";

endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline stage: a synchronous-reset register when STAGES=1,
// a plain wire when STAGES=0.
module dsp_pipe_reg #(
  parameter int DATA_W = 18,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  if (STAGES != 0 && STAGES != 1) begin : g_bad_stages
    $error("dsp_pipe_reg: STAGES must be 0 or 1");
  end

  if (STAGES == 1) begin : g_reg
    // Capture one value per clock; reset flushes the stage to zero.
    always_ff @(posedge clk) begin
      if (rst) q <= '0;
      else     q <= d;
    end
  end else begin : g_wire
    assign q = d;
  end

endmodule

// File: rtl/dsp48a1.sv
// Pipelined unsigned multiply-accumulate slice: P = A*B + C +/- D, modulo 2^48.
// Each operand path, the product and the result can be registered
// independently; paths are not balanced automatically.
module dsp48a1
  import dsp48a1_pkg::*;
#(
  parameter string OPERATION = "ADD",
  parameter int    AREG      = 1,
  parameter int    BREG      = 1,
  parameter int    CREG      = 1,
  parameter int    DREG      = 1,
  parameter int    MREG      = 0,
  parameter int    PREG      = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [A_W-1:0] A,
  input  logic [B_W-1:0] B,
  input  logic [C_W-1:0] C,
  input  logic [D_W-1:0] D,
  output logic [P_W-1:0] P
);

  logic [A_W-1:0] a_p0;
  logic [B_W-1:0] b_p0;
  logic [C_W-1:0] c_p0;
  logic [D_W-1:0] d_p0;
  logic [M_W-1:0] mult_p0;
  logic [M_W-1:0] mult_p1;
  logic [P_W-1:0] sum_p1;

  // Unknown OPERATION strings are rejected at elaboration time so a typo
  // cannot silently fall back to one of the two modes.
  if (OPERATION != OP_ADD && OPERATION != OP_SUB) begin : g_bad_op
    $error("dsp48a1: OPERATION must be \"ADD\" or \"SUBTRACT\"");
  end

  // ---- Input stage: optional A/B/C/D registers ----
  dsp_pipe_reg #(.DATA_W(A_W), .STAGES(AREG)) u_areg (
    .clk(clk), .rst(rst), .d(A), .q(a_p0)
  );
  dsp_pipe_reg #(.DATA_W(B_W), .STAGES(BREG)) u_breg (
    .clk(clk), .rst(rst), .d(B), .q(b_p0)
  );
  dsp_pipe_reg #(.DATA_W(C_W), .STAGES(CREG)) u_creg (
    .clk(clk), .rst(rst), .d(C), .q(c_p0)
  );
  dsp_pipe_reg #(.DATA_W(D_W), .STAGES(DREG)) u_dreg (
    .clk(clk), .rst(rst), .d(D), .q(d_p0)
  );

  // ---- Multiply stage: 18x18 unsigned product, optional M register ----
  assign mult_p0 = M_W'(a_p0) * M_W'(b_p0);

  dsp_pipe_reg #(.DATA_W(M_W), .STAGES(MREG)) u_mreg (
    .clk(clk), .rst(rst), .d(mult_p0), .q(mult_p1)
  );

  // ---- Add/subtract stage: wraps modulo 2^48, no carry or borrow out ----
  if (OPERATION == OP_SUB) begin : g_sub
    assign sum_p1 = P_W'(mult_p1) + c_p0 - P_W'(d_p0);
  end else begin : g_add
    assign sum_p1 = P_W'(mult_p1) + c_p0 + P_W'(d_p0);
  end

  // ---- Output stage: optional P register ----
  dsp_pipe_reg #(.DATA_W(P_W), .STAGES(PREG)) u_preg (
    .clk(clk), .rst(rst), .d(sum_p1), .q(P)
  );

endmodule

// File: tb/tb_dsp48a1.sv
// Directed bench for dsp48a1: an ADD and a SUBTRACT instance in the default
// 2-clock configuration share one stimulus stream; expected results are
// hand-computed constants.
module tb_dsp48a1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] a = '0;
  logic [17:0] b = '0;
  logic [47:0] c = '0;
  logic [17:0] d = '0;
  logic [47:0] p_add;
  logic [47:0] p_sub;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp48a1 #(.OPERATION("ADD")) u_add (
    .clk(clk), .rst(rst), .A(a), .B(b), .C(c), .D(d), .P(p_add)
  );

  dsp48a1 #(.OPERATION("SUBTRACT")) u_sub (
    .clk(clk), .rst(rst), .A(a), .B(b), .C(c), .D(d), .P(p_sub)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ops(input logic [17:0] av, input logic [17:0] bv,
                         input logic [47:0] cv, input logic [17:0] dv);
    a = av; b = bv; c = cv; d = dv;
  endtask

  task automatic check(input string tag, input logic [47:0] obs,
                       input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%012h expected 0x%012h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held for two cycles with non-zero operands on the inputs.
    @(negedge clk);
    rst = 1'b1;
    set_ops(18'd5, 18'd5, 48'd5, 18'd5);
    tick();
    check("rst_c1_add", p_add, 48'h0);
    check("rst_c1_sub", p_sub, 48'h0);
    tick();
    check("rst_c2_add", p_add, 48'h0);
    check("rst_c2_sub", p_sub, 48'h0);

    // Release: first edge loads the operands, second edge shows the result.
    rst = 1'b0;
    tick();
    check("post_rst_lat1_add", p_add, 48'h0);
    tick();
    check("post_rst_add", p_add, 48'h23);
    check("post_rst_sub", p_sub, 48'h19);

    // Basic set with exact 2-cycle latency.
    set_ops(18'd1, 18'd2, 48'd3, 18'd4);
    tick();
    check("basic_lat1_add", p_add, 48'h23);
    tick();
    check("basic_add", p_add, 48'h9);
    check("basic_sub", p_sub, 48'h1);

    // Second set.
    set_ops(18'd2, 18'd3, 48'h10, 18'd1);
    tick();
    tick();
    check("set2_add", p_add, 48'h17);
    check("set2_sub", p_sub, 48'h15);

    // Wide operands, no wrap.
    set_ops(18'h3FFF, 18'h3FFF, 48'hFFFF_FFFF, 18'h3FFF);
    tick();
    tick();
    check("wide_add", p_add, 48'h0001_0FFF_BFFF);
    check("wide_sub", p_sub, 48'h0001_0FFF_4001);

    // All-ones operands: sum wraps modulo 2^48.
    set_ops(18'h3FFFF, 18'h3FFFF, 48'hFFFF_FFFF_FFFF, 18'h3FFFF);
    tick();
    tick();
    check("ones_add", p_add, 48'h000F_FFFB_FFFF);
    check("ones_sub", p_sub, 48'h000F_FFF4_0001);

    // Borrow on subtract wraps to all ones.
    set_ops(18'd0, 18'd0, 48'd0, 18'd1);
    tick();
    tick();
    check("borrow_sub", p_sub, 48'hFFFF_FFFF_FFFF);
    check("borrow_add", p_add, 48'h1);

    // Back-to-back: three sets on consecutive cycles.
    set_ops(18'd1, 18'd2, 48'd3, 18'd4);
    tick();
    set_ops(18'd2, 18'd3, 48'h10, 18'd1);
    tick();
    check("b2b_1_add", p_add, 48'h9);
    check("b2b_1_sub", p_sub, 48'h1);
    set_ops(18'h3FFF, 18'h3FFF, 48'hFFFF_FFFF, 18'h3FFF);
    tick();
    check("b2b_2_add", p_add, 48'h17);
    check("b2b_2_sub", p_sub, 48'h15);
    set_ops(18'd0, 18'd0, 48'd0, 18'd0);
    tick();
    check("b2b_3_add", p_add, 48'h0001_0FFF_BFFF);

    // Mid-stream reset: in-flight set must not emerge.
    set_ops(18'd1, 18'd2, 48'd3, 18'd4);
    tick();
    check("ms_pre_add", p_add, 48'h0);
    set_ops(18'd2, 18'd3, 48'h10, 18'd1);
    tick();
    check("ms_first_add", p_add, 48'h9);
    rst = 1'b1;
    set_ops(18'h3FFF, 18'h3FFF, 48'hFFFF_FFFF, 18'h3FFF);
    tick();
    check("ms_rst_add", p_add, 48'h0);
    check("ms_rst_sub", p_sub, 48'h0);
    rst = 1'b0;
    set_ops(18'd1, 18'd2, 48'd3, 18'd4);
    tick();
    check("ms_flushed_add", p_add, 48'h0);
    check("ms_flushed_sub", p_sub, 48'h0);
    tick();
    check("ms_resume_add", p_add, 48'h9);
    check("ms_resume_sub", p_sub, 48'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
